// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a double-buffered BCD frame.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits in slots 3..1.
module display_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 12500,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] digit_data,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic        load_ready,
  output logic [6:0]  segmentos,
  output logic [3:0]  displays,
  output logic        frame_start,
  output logic        state_dbg
);

  // Handshake: a frame transfers on a cycle where load and load_ready are both high;
  // load_ready drops the cycle after a transfer and returns the cycle after the commit.

  localparam int unsigned MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  state_t        state, state_nx;
  logic [1:0]    slot, slot_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          commit;
  logic [15:0]   act_data, shd_data;
  logic [3:0]    act_en, shd_en;
  logic          pending;
  logic [3:0]    nibble;
  logic [3:0]    suppress;
  logic          show;
  logic [6:0]    seg_nx;
  logic [3:0]    dis_nx;
  logic          fs_nx;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111110;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    cnt_nx   = cnt + CW'(1);
    commit   = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = DRIVE;
          cnt_nx   = '0;
        end
      end
      DRIVE: begin
        if (cnt == DWELL_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          slot_nx  = slot + 2'd1;
          // Frame boundary: the only point where a new frame may become visible.
          commit   = pending && (slot == 2'd3);
        end
      end
      default: begin
        state_nx = BLANK;
        cnt_nx   = '0;
      end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;
  always_comb begin
    suppress   = '0;
    zero_above = 1'b1;
    // Walk down from slot 3; any enabled non-zero digit stops suppression below it.
    for (int k = 3; k >= 1; k--) begin
      suppress[k] = zero_above && (act_data[4*k +: 4] == 4'd0);
      if (act_en[k] && (act_data[4*k +: 4] != 4'd0)) zero_above = 1'b0;
    end
  end
`else
  assign suppress = '0;
`endif

  always_comb begin
    nibble = act_data[{slot, 2'b00} +: 4];
    show   = (state == DRIVE) && act_en[slot] && !suppress[slot];
    seg_nx = show ? decode(nibble) : 7'b1111111;
    dis_nx = show ? ~(4'b0001 << slot) : 4'b1111;
    fs_nx  = (state == BLANK) && (slot == 2'd0) && (cnt == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= BLANK;
      slot        <= '0;
      cnt         <= '0;
      act_data    <= '0;
      act_en      <= '0;
      shd_data    <= '0;
      shd_en      <= '0;
      pending     <= 1'b0;
      segmentos   <= 7'b1111111;
      displays    <= 4'b1111;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      slot        <= slot_nx;
      cnt         <= cnt_nx;
      segmentos   <= seg_nx;
      displays    <= dis_nx;
      frame_start <= fs_nx;
      if (commit) begin
        act_data <= shd_data;
        act_en   <= shd_en;
        pending  <= 1'b0;
      end else if (load && !pending) begin
        shd_data <= digit_data;
        shd_en   <= digit_en;
        pending  <= 1'b1;
      end
    end
  end

  assign load_ready = ~pending;
  assign state_dbg  = (state == DRIVE);

endmodule
